data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/mem_pkg.sv | 42 ++++
 rtl/byte_lane_unit.sv | 59 +++++
 rtl/data_mem_ctrl.sv | 157 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller:
// FSM states, funct3 access codes, access sizes and byte-enable patterns.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Unlisted funct3 codes fall back to a full-word access.
    function automatic logic [1:0] decode_size(input logic [2:0] f3);
        logic [1:0] sz;
        case (f3)
            F3_LB, F3_LBU: sz = SZ_BYTE;
            F3_LH, F3_LHU: sz = SZ_HALF;
            default:       sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_unsigned(input logic [2:0] f3);
        return (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane steering: byte enables and replicated store data,
// alignment check, and selection plus sign/zero extension of load data.
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    input  logic [31:0] ram_rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        aligned
);

    logic [1:0]  size;
    logic        uns;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Decode the access size and steer data between core and RAM lanes.
    always_comb begin
        size       = decode_size(funct3);
        uns        = is_unsigned(funct3);
        be         = BE_NONE;
        lane_wdata = wdata;
        load_data  = ram_rdata;
        aligned    = 1'b1;
        lane_half  = byte_off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (byte_off)
            2'd0:    lane_byte = ram_rdata[7:0];
            2'd1:    lane_byte = ram_rdata[15:8];
            2'd2:    lane_byte = ram_rdata[23:16];
            default: lane_byte = ram_rdata[31:24];
        endcase
        case (size)
            SZ_BYTE: begin
                be         = BE_BYTE0 << byte_off;
                lane_wdata = {4{wdata[7:0]}};
                load_data  = uns ? {24'h0, lane_byte}
                                 : {{24{lane_byte[7]}}, lane_byte};
            end
            SZ_HALF: begin
                be         = byte_off[1] ? BE_HALF_HI : BE_HALF_LO;
                aligned    = ~byte_off[0];
                lane_wdata = {2{wdata[15:0]}};
                load_data  = uns ? {16'h0, lane_half}
                                 : {{16{lane_half[15]}}, lane_half};
            end
            default: begin
                be         = BE_WORD;
                aligned    = (byte_off == 2'd0);
                lane_wdata = wdata;
                load_data  = ram_rdata;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller between a pipeline core and a wait-stated RAM.
// Optional feature: define DMEM_ERR_CNT_EN to count misaligned accesses
// in err_count (saturating); otherwise err_count is tied to zero.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        funct3,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              misaligned,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [31:0]       ram_rdata,
    output logic [15:0]       err_count
);

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic        load_q;
    logic        req;
    logic        is_store;
    logic        is_load;
    logic        cur_load;
    logic        accept;
    logic        active;
    logic        capture;
    logic        aligned;
    logic [3:0]  be_w;
    logic [31:0] lane_wdata_w;
    logic [31:0] load_data_w;
    logic        unused_addr;

    // A simultaneous read and write is handled as a store.
    assign req      = mem_read | mem_write;
    assign is_store = mem_write;
    assign is_load  = mem_read & ~mem_write;
    assign cur_load = (state == IDLE) ? is_load : load_q;

    byte_lane_unit u_lanes (
        .funct3     (funct3),
        .byte_off   (addr[1:0]),
        .wdata      (wdata),
        .ram_rdata  (ram_rdata),
        .be         (be_w),
        .lane_wdata (lane_wdata_w),
        .load_data  (load_data_w),
        .aligned    (aligned)
    );

    // Next-state and handshake decode; reset suppresses every strobe.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        active     = 1'b0;
        stall      = 1'b0;
        misaligned = 1'b0;
        case (state)
            IDLE: begin
                if (req && !reset) begin
                    if (aligned) begin
                        accept     = 1'b1;
                        active     = 1'b1;
                        stall      = 1'b1;
                        state_next = (WAIT_CYCLES > 0) ? WAIT : DONE;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            WAIT: begin
                active = !reset;
                stall  = !reset;
                if (wait_cnt <= 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Wait-state down-counter and the load/store flag of the access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 4'd0;
            load_q   <= 1'b0;
        end else if (accept) begin
            wait_cnt <= 4'(WAIT_CYCLES);
            load_q   <= is_load;
        end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    assign capture = (state_next == DONE) && (state != DONE) && cur_load;

    // Load result is captured as the FSM enters DONE and held until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= 32'h0;
        end else if (capture) begin
            rdata <= load_data_w;
        end
    end

    assign ram_addr    = addr[ADDR_W+1:2];
    assign unused_addr = ^addr[31:ADDR_W+2];
    assign ram_wdata   = lane_wdata_w;
    assign ram_be      = active ? be_w : BE_NONE;
    assign ram_we      = accept & is_store;
    assign ram_re      = active & cur_load;

`ifdef DMEM_ERR_CNT_EN
    logic [15:0] err_q;

    // Saturating count of misaligned request cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 16'h0;
        end else if (misaligned && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 16'h0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a driver issues core requests and
// queues expected responses from a byte-array memory model; a monitor
// compares the RAM strobes, stall length, rdata and err_count.
module tb_data_mem_ctrl;

    localparam int AW = 10;
    localparam int WC = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [31:0]   addr = 32'h0;
    logic [31:0]   wdata = 32'h0;
    logic [2:0]    funct3 = 3'b0;
    logic [31:0]   rdata;
    logic          stall;
    logic          misaligned;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_be;
    logic          ram_we;
    logic          ram_re;
    logic [31:0]   ram_rdata;
    logic [15:0]   err_count;

    data_mem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .funct3     (funct3),
        .rdata      (rdata),
        .stall      (stall),
        .misaligned (misaligned),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_be     (ram_be),
        .ram_we     (ram_we),
        .ram_re     (ram_re),
        .ram_rdata  (ram_rdata),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // RAM environment: asynchronous read, byte-enabled synchronous write.
    logic [31:0] ram [0:(1<<AW)-1];
    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
    end

    typedef struct {
        bit          misal;
        bit          is_store;
        logic [9:0]  ram_addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [15:0] err;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  ref_mem [0:(4<<AW)-1];
    logic [31:0] last_rdata = 32'h0;
    int          err_ref = 0;
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one request; entered and left just after a rising edge.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [2:0] f3);
        exp_t        e;
        int          sz;
        int          ea;
        logic [31:0] v;
        bit          done;
        sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        ea = int'(a % (4 << AW));
        e.misal    = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'd0);
        e.is_store = wr;
        e.ram_addr = 10'((a / 4) % (1 << AW));
        e.be       = (sz == 1) ? 4'(1 << (a % 4)) : (sz == 2) ? 4'(3 << (a % 4)) : 4'hF;
        e.wdata    = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
        e.err      = 16'h0;
        if (e.misal) begin
`ifdef DMEM_ERR_CNT_EN
            if (err_ref < 65535) err_ref++;
            e.err = 16'(err_ref);
`endif
        end else if (wr) begin
            for (int i = 0; i < sz; i++) ref_mem[ea + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[ea + i];
            if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            last_rdata = v;
        end
        e.rdata = last_rdata;
        q.push_back(e);
        mem_read = rd; mem_write = wr; addr = a; wdata = wd; funct3 = f3;
        if (!e.misal) begin
            done = 1'b0;
            for (int n = 0; n < 30 && !done; n++) begin
                @(negedge clk);
                if (!stall) done = 1'b1;
            end
            if (!done) begin
                checks++; errors++;
                $display("[TB] FAIL stall_timeout: stall still high, required release within 30 cycles");
            end
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    // Monitor: compares DUT behaviour against queued expectations.
    initial begin
        exp_t        cur;
        exp_t        e;
        bit          prev_stall = 1'b0;
        bit          err_pending = 1'b0;
        logic [15:0] err_exp = 16'h0;
        int          stall_cnt = 0;
        cur = '{default: 0};
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (err_pending) begin
                    checkOutput("err_count", 32'(err_count), 32'(err_exp));
                    err_pending = 1'b0;
                end
                if (misaligned) begin
                    if (q.size() == 0 || !q[0].misal) begin
                        checks++; errors++;
                        $display("[TB] FAIL misaligned: got 1 expected 0");
                    end else begin
                        e = q.pop_front();
                        checkOutput("misal_stall", 32'(stall), 32'd0);
                        checkOutput("misal_ram_re", 32'(ram_re), 32'd0);
                        checkOutput("misal_ram_we", 32'(ram_we), 32'd0);
                        err_pending = 1'b1;
                        err_exp = e.err;
                    end
                end else if (stall && !prev_stall) begin
                    if (q.size() == 0 || q[0].misal) begin
                        checks++; errors++;
                        $display("[TB] FAIL access_start: got stall=1 expected no access");
                    end else begin
                        cur = q[0];
                        stall_cnt = 1;
                        checkOutput("ram_addr", 32'(ram_addr), 32'(cur.ram_addr));
                        checkOutput("ram_be", 32'(ram_be), 32'(cur.be));
                        checkOutput("ram_we", 32'(ram_we), 32'(cur.is_store));
                        checkOutput("ram_re", 32'(ram_re), 32'(!cur.is_store));
                        if (cur.is_store) checkOutput("ram_wdata", ram_wdata, cur.wdata);
                    end
                end else if (stall && prev_stall) begin
                    stall_cnt++;
                    checkOutput("wait_ram_we", 32'(ram_we), 32'd0);
                    checkOutput("wait_ram_re", 32'(ram_re), 32'(!cur.is_store));
                    checkOutput("wait_ram_addr", 32'(ram_addr), 32'(cur.ram_addr));
                end else if (!stall && prev_stall) begin
                    if (q.size() != 0 && !q[0].misal) begin
                        e = q.pop_front();
                        checkOutput("stall_cycles", 32'(stall_cnt), 32'(WC + 1));
                        checkOutput("rdata", rdata, e.rdata);
                        checkOutput("done_ram_re", 32'(ram_re), 32'd0);
                        checkOutput("done_ram_we", 32'(ram_we), 32'd0);
                    end
                end
            end
            prev_stall = stall;
        end
    end

    // Main sequence: reset, directed cases, random traffic, mid-access reset.
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
        for (int i = 0; i < (4 << AW); i++) ref_mem[i] = 8'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_misaligned", 32'(misaligned), 32'd0);
        checkOutput("reset_ram_we", 32'(ram_we), 32'd0);
        checkOutput("reset_ram_re", 32'(ram_re), 32'd0);
        checkOutput("reset_ram_be", 32'(ram_be), 32'd0);
        checkOutput("reset_err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        applyStimulus(0, 1, 32'h10, 32'hDEADBEEF, 3'b010);
        applyStimulus(1, 0, 32'h10, 32'h0, 3'b010);
        applyStimulus(0, 1, 32'h10, 32'h80FFFFFF, 3'b010);
        applyStimulus(1, 0, 32'h13, 32'h0, 3'b000);
        applyStimulus(1, 0, 32'h13, 32'h0, 3'b100);
        applyStimulus(0, 1, 32'h22, 32'h1234ABCD, 3'b001);
        applyStimulus(1, 0, 32'h20, 32'h0, 3'b010);
        applyStimulus(0, 1, 32'h40, 32'h11111111, 3'b010);
        applyStimulus(1, 0, 32'h06, 32'h0, 3'b010);
        applyStimulus(1, 1, 32'h40, 32'h55AA1234, 3'b010);
        applyStimulus(1, 0, 32'h40, 32'h0, 3'b010);
        applyStimulus(1, 0, 32'h1004, 32'h0, 3'b010);
        applyStimulus(1, 0, 32'h23, 32'h0, 3'b001);

        for (int t = 0; t < 120; t++) begin
            int op;
            op = $urandom_range(0, 2);
            applyStimulus(op != 1, op != 0, {$urandom_range(0, 15), $urandom_range(0, 4095)},
                          $urandom, 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        // Abandon a load with reset in its second wait cycle.
        repeat (3) begin @(posedge clk); #1; end
        mon_en = 1'b0;
        mem_read = 1'b1; addr = 32'h24; funct3 = 3'b010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; mem_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_stall", 32'(stall), 32'd0);
        checkOutput("post_reset_ram_re", 32'(ram_re), 32'd0);
        checkOutput("post_reset_ram_be", 32'(ram_be), 32'd0);
        checkOutput("post_reset_rdata", rdata, 32'h0);
        checkOutput("post_reset_err_count", 32'(err_count), 32'd0);
        last_rdata = 32'h0;
        err_ref = 0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        applyStimulus(1, 0, 32'h10, 32'h0, 3'b010);
        applyStimulus(1, 0, 32'h32, 32'h0, 3'b010);
        applyStimulus(1, 0, 32'h22, 32'h0, 3'b101);

        for (int n = 0; n < 50 && q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        checkOutput("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
